// File: rtl/interpret_val_pipe.sv
// -----------------------------------------------------------------------------
// interpret_val_pipe
//
// Two-stage valid/ready pipeline that interprets a raw sample as either
// unsigned or two's-complement signed and emits its unsigned magnitude plus
// a sign flag. It also keeps a few statistics about the results that are
// consumed downstream.
//
// Stage S1 registers the raw sample and its mode. Stage S2 registers the
// converted magnitude, sign and zero flag. Each stage has its own valid bit.
// S2 refills in the same cycle it is drained, so while out_ready is held high
// the pipeline sustains one sample per cycle.
//
// Optional feature (compile-time macro):
//   INTERP_PEAK_EN  tracks the largest consumed magnitude and its sign in
//                   peak_val / peak_neg. When undefined, both are tied to 0
//                   and the tracking registers and comparator are not built.
//
// Parameters:
//   WIDTH       data and magnitude width, legal range 2..32
//   CNT_W       width of the saturating sample counter
//
// Ports:
//   clk         system clock, rising edge active
//   rst_n       asynchronous active-low reset
//   in_valid    producer presents a sample
//   in_ready    sample accepted this cycle (combinational from out_ready)
//   in_data     raw sample
//   in_mode     1 = two's-complement signed, 0 = unsigned
//   out_valid   result available
//   out_ready   consumer accepts the result
//   out_val     unsigned magnitude
//   out_neg     1 = sample was negative
//   out_zero    1 when out_val is 0
//   clr_stats   synchronous clear of sample_cnt / peak_val / peak_neg
//   sample_cnt  number of results consumed, saturating
//   peak_val    largest magnitude consumed (0 when feature disabled)
//   peak_neg    sign of the sample held in peak_val
// -----------------------------------------------------------------------------
module interpret_val_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_val,
    output logic             out_neg,
    output logic             out_zero,

    input  logic             clr_stats,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [WIDTH-1:0] peak_val,
    output logic             peak_neg
);

    // S1 state: raw sample and how to interpret it
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic             s1_mode;

    // Handshake and stage-advance strobes
    logic             in_fire;
    logic             out_fire;
    logic             s2_load;

    // Conversion of the S1 sample, registered into S2
    logic [WIDTH-1:0] conv_val;
    logic             conv_neg;

    // Stage control: S2 accepts when empty or being drained in this cycle
    assign out_fire = out_valid & out_ready;
    assign s2_load  = s1_valid & (~out_valid | out_fire);
    assign in_ready = ~s1_valid | s2_load;
    assign in_fire  = in_valid & in_ready;

    // Magnitude/sign conversion. The most negative value wraps onto itself
    // (e.g. 0x80 -> 0x80 at WIDTH 8), which is exactly its unsigned magnitude.
    always_comb begin
        conv_val = s1_data;
        conv_neg = 1'b0;
        if (s1_mode && s1_data[WIDTH-1]) begin
            conv_val = WIDTH'(~s1_data + WIDTH'(1));
            conv_neg = 1'b1;
        end
    end

    // S1 register: loads on input handshake, empties when S2 takes the sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_mode  <= in_mode;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // S2 register: result payload only changes on a load, so it holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_val   <= '0;
            out_neg   <= 1'b0;
            out_zero  <= 1'b1;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out_val   <= conv_val;
                out_neg   <= conv_neg;
                out_zero  <= (conv_val == '0);
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Saturating count of consumed results; a clear wins over a coincident handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
        end else begin
            if (clr_stats) begin
                sample_cnt <= '0;
            end else if (out_fire && (sample_cnt != '1)) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

`ifdef INTERP_PEAK_EN
    // Peak magnitude tracker; strict greater-than so ties keep the earlier sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_val <= '0;
            peak_neg <= 1'b0;
        end else begin
            if (clr_stats) begin
                peak_val <= '0;
                peak_neg <= 1'b0;
            end else if (out_fire && (out_val > peak_val)) begin
                peak_val <= out_val;
                peak_neg <= out_neg;
            end
        end
    end
`else
    // Peak tracking not built
    assign peak_val = '0;
    assign peak_neg = 1'b0;
`endif

endmodule

// File: tb/tb_interpret_val_pipe.sv
// -----------------------------------------------------------------------------
// tb_interpret_val_pipe
//
// Directed self-checking bench for interpret_val_pipe at WIDTH 8. A second
// instance with CNT_W 2 shares the traffic so counter saturation is visible.
// Peak expectations follow INTERP_PEAK_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_interpret_val_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 16;

`ifdef INTERP_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_val;
    logic             out_neg;
    logic             out_zero;
    logic             clr_stats;
    logic [CNT_W-1:0] sample_cnt;
    logic [WIDTH-1:0] peak_val;
    logic             peak_neg;

    // Saturation instance
    logic             clr_sat;
    logic             sat_in_ready;
    logic             sat_out_valid;
    logic [WIDTH-1:0] sat_out_val;
    logic             sat_out_neg;
    logic             sat_out_zero;
    logic [1:0]       sat_cnt;
    logic [WIDTH-1:0] sat_peak_val;
    logic             sat_peak_neg;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;
    logic [8:0] got_q[$];

    logic [7:0] b2b_d    [3] = '{8'h80, 8'h80, 8'h00};
    logic       b2b_m    [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] b2b_val  [3] = '{8'h80, 8'h80, 8'h00};
    logic       b2b_neg  [3] = '{1'b1, 1'b0, 1'b0};
    logic       b2b_zero [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] stall_d  [3] = '{8'h11, 8'h22, 8'h33};

    interpret_val_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_val    (out_val),
        .out_neg    (out_neg),
        .out_zero   (out_zero),
        .clr_stats  (clr_stats),
        .sample_cnt (sample_cnt),
        .peak_val   (peak_val),
        .peak_neg   (peak_neg)
    );

    interpret_val_pipe #(.WIDTH(WIDTH), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (sat_in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (sat_out_valid),
        .out_ready  (out_ready),
        .out_val    (sat_out_val),
        .out_neg    (sat_out_neg),
        .out_zero   (sat_out_zero),
        .clr_stats  (clr_sat),
        .sample_cnt (sat_cnt),
        .peak_val   (sat_peak_val),
        .peak_neg   (sat_peak_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake monitor, sampled mid-cycle where inputs are stable
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                got_q.push_back({out_neg, out_val});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample end to end with out_ready high; returns after its handshake edge
    task automatic send_one(input logic [7:0] d, input logic m);
        int n_acc;
        int n_hs;
        bit done;
        n_acc = acc_cnt;
        n_hs = hs_cnt;
        done = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_mode = m;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (acc_cnt != n_acc) in_valid = 1'b0;
            if (hs_cnt != n_hs) done = 1'b1;
        end
        in_valid = 1'b0;
        check("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_out_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int acc0;
        int hs0;
        int idx;
        bit drained;

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_mode = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        clr_sat = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_val", 32'(out_val), 32'h0);
        check("rst_out_neg", 32'(out_neg), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        check("rst_cnt", 32'(sample_cnt), 32'd0);
        check("rst_peak_val", 32'(peak_val), 32'h0);
        check("rst_peak_neg", 32'(peak_neg), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single signed sample 0xF6 -> magnitude 0x0A negative, latency 2
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hF6;
        in_mode = 1'b1;
        tick();
        in_valid = 1'b0;
        check("f6_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check("f6_valid", 32'(out_valid), 32'd1);
        check("f6_val", 32'(out_val), 32'h0A);
        check("f6_neg", 32'(out_neg), 32'd1);
        check("f6_zero", 32'(out_zero), 32'd0);
        tick();
        check("f6_drained", 32'(out_valid), 32'd0);
        check("f6_cnt", 32'(sample_cnt), 32'd1);
        check("f6_sat_cnt", 32'(sat_cnt), 32'd1);

        // Back-to-back: 0x80 signed, 0x80 unsigned, 0x00 signed
        for (int k = 1; k <= 4; k++) begin
            if (k <= 3) begin
                in_valid = 1'b1;
                in_data = b2b_d[k-1];
                in_mode = b2b_m[k-1];
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k >= 2) begin
                check($sformatf("b2b%0d_valid", k - 2), 32'(out_valid), 32'd1);
                check($sformatf("b2b%0d_val", k - 2), 32'(out_val), 32'(b2b_val[k-2]));
                check($sformatf("b2b%0d_neg", k - 2), 32'(out_neg), 32'(b2b_neg[k-2]));
                check($sformatf("b2b%0d_zero", k - 2), 32'(out_zero), 32'(b2b_zero[k-2]));
            end
        end
        tick();
        check("b2b_cnt", 32'(sample_cnt), 32'd4);
        check("b2b_sat_cnt", 32'(sat_cnt), 32'd3);

        // Stall: out_ready low for 5 edges with three samples offered
        out_ready = 1'b0;
        acc0 = acc_cnt;
        idx = 0;
        in_valid = 1'b1;
        in_data = stall_d[0];
        in_mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (acc_cnt - acc0 > idx) begin
                idx = acc_cnt - acc0;
                if (idx < 3) in_data = stall_d[idx];
                else in_valid = 1'b0;
            end
            if (c >= 1) begin
                check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
                check($sformatf("stall%0d_val", c), 32'(out_val), 32'h11);
            end
        end
        check("stall_accepted", 32'(acc_cnt - acc0), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);

        // Release and collect the drained results
        got_q.delete();
        hs0 = hs_cnt;
        out_ready = 1'b1;
        drained = 1'b0;
        for (int c = 0; c < 12 && !drained; c++) begin
            tick();
            if (acc_cnt - acc0 > idx) begin
                idx = acc_cnt - acc0;
                if (idx < 3) in_data = stall_d[idx];
                else in_valid = 1'b0;
            end
            if (hs_cnt - hs0 >= 3 && !in_valid) drained = 1'b1;
        end
        in_valid = 1'b0;
        tick();
        check("drain_done", 32'(drained), 32'd1);
        check("drain_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size())
                check($sformatf("drain%0d_data", i), 32'(got_q[i]), 32'({1'b0, stall_d[i]}));
        end
        check("drain_accepted", 32'(acc_cnt - acc0), 32'd3);
        check("drain_cnt", 32'(sample_cnt), 32'd7);
        check("drain_sat_cnt", 32'(sat_cnt), 32'd3);

        // Peak sequence 0x05, 0xF0, 0x10, 0x7F (signed)
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_cnt", 32'(sample_cnt), 32'd0);
        send_one(8'h05, 1'b1);
        send_one(8'hF0, 1'b1);
        check("pk_f0_val", 32'(peak_val), PEAK_EN ? 32'h10 : 32'h0);
        check("pk_f0_neg", 32'(peak_neg), PEAK_EN ? 32'd1 : 32'd0);
        send_one(8'h10, 1'b1);
        check("pk_tie_neg", 32'(peak_neg), PEAK_EN ? 32'd1 : 32'd0);
        send_one(8'h7F, 1'b1);
        check("pk_end_val", 32'(peak_val), PEAK_EN ? 32'h7F : 32'h0);
        check("pk_end_neg", 32'(peak_neg), 32'd0);
        check("pk_cnt", 32'(sample_cnt), 32'd4);

        // clr_stats on the same edge as a handshake
        out_ready = 1'b0;
        hs0 = hs_cnt;
        in_valid = 1'b1;
        in_data = 8'h7E;
        in_mode = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_out_valid("clrhs_wait");
        out_ready = 1'b1;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clrhs_handshake", 32'(hs_cnt - hs0), 32'd1);
        check("clrhs_cnt", 32'(sample_cnt), 32'd0);
        check("clrhs_peak", 32'(peak_val), 32'h0);
        check("clrhs_valid", 32'(out_valid), 32'd0);

        // clr_stats alone leaves a stalled result untouched
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h01;
        tick();
        in_valid = 1'b0;
        wait_out_valid("clrdata_wait");
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clrdata_valid", 32'(out_valid), 32'd1);
        check("clrdata_val", 32'(out_val), 32'h01);
        out_ready = 1'b1;
        tick();
        check("clrdata_cnt", 32'(sample_cnt), 32'd1);
        check("clrdata_peak", 32'(peak_val), PEAK_EN ? 32'h01 : 32'h0);
        check("sat_final", 32'(sat_cnt), 32'd3);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h44;
        tick();
        in_data = 8'h55;
        tick();
        in_valid = 1'b0;
        check("arst_full_valid", 32'(out_valid), 32'd1);
        check("arst_full_ready", 32'(in_ready), 32'd0);
        hs0 = hs_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_val", 32'(out_val), 32'h0);
        check("arst_zero", 32'(out_zero), 32'd1);
        check("arst_cnt", 32'(sample_cnt), 32'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check("arst_no_hs", 32'(hs_cnt - hs0), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("arst_post_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data = 8'hFD;
        in_mode = 1'b1;
        tick();
        in_valid = 1'b0;
        check("arst_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check("arst_lat2_valid", 32'(out_valid), 32'd1);
        check("arst_lat2_val", 32'(out_val), 32'h03);
        check("arst_lat2_neg", 32'(out_neg), 32'd1);
        tick();
        check("arst_hs", 32'(hs_cnt - hs0), 32'd1);
        check("arst_cnt_after", 32'(sample_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interpret_val_pipe.md
INTERPRET_VAL_PIPE -- requirements
Module: interpret_val_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data and magnitude width in bits; legal values are 2 to 32.
REQ-002 Parameter CNT_W, default 16, width of the sample counter.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer presents a sample.
REQ-006 in_ready  output  1  block accepts the sample this cycle.
REQ-007 in_data  input  WIDTH  raw sample.
REQ-008 in_mode  input  1  1 = two's-complement signed, 0 = unsigned; qualified by in_valid.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_val  output  WIDTH  unsigned magnitude.
REQ-012 out_neg  output  1  sign; 1 = negative.
REQ-013 out_zero  output  1  1 when out_val equals 0.
REQ-014 clr_stats  input  1  synchronous clear of the statistics registers.
REQ-015 sample_cnt  output  CNT_W  count of results consumed.
REQ-016 peak_val  output  WIDTH  largest magnitude consumed (see Configuration).
REQ-017 peak_neg  output  1  sign of the sample held in peak_val.

Function
REQ-018 The block shall be a two-stage pipeline: S1 input register, S2 output register; each stage has its own valid bit.
REQ-019 The input handshake shall complete when in_valid and in_ready are both high; the output handshake shall complete when out_valid and out_ready are both high.
REQ-020 S2 shall load when S1 is valid and (S2 is empty or the output handshake completes this cycle).
REQ-021 in_ready shall equal (S1 empty) or (S2 loads this cycle); the combinational path from out_ready to in_ready is permitted.
REQ-022 Minimum latency shall be 2 cycles from input handshake to out_valid; sustained throughput shall be 1 sample per cycle while out_ready is held high.
REQ-023 Conversion from S1 to S2, signed mode with data MSB 1: out_val = (~data + 1) mod 2^WIDTH, out_neg = 1.
REQ-024 Conversion, signed mode with MSB 0, or unsigned mode: out_val = data, out_neg = 0.
REQ-025 The most negative input, e.g. 0x80 at WIDTH 8, shall yield out_val 0x80 (magnitude 128) with out_neg 1; it shall not saturate or flag.
REQ-026 out_zero shall be derived from the registered out_val; a zero input never sets out_neg.
REQ-027 out_val, out_neg and out_zero shall hold stable while out_valid is high and out_ready is low.
REQ-028 sample_cnt shall increment on each output handshake and saturate at all-ones.
REQ-029 When clr_stats coincides with an output handshake, clr_stats shall take precedence and that sample shall not be counted or peak-compared.
REQ-030 clr_stats shall not affect pipeline data or valid bits.

Reset
REQ-031 When rst_n is low, both stage valid bits shall clear immediately; out_valid = 0 and in_ready = 1 after reset.
REQ-032 During reset: out_val = 0, out_neg = 0, out_zero = 1, sample_cnt = 0, peak_val = 0, peak_neg = 0.
REQ-033 Reset asserted mid-transfer shall discard in-flight samples without producing any output handshake.

Configuration
REQ-034 With macro INTERP_PEAK_EN defined, on each counted output handshake: if out_val > peak_val (unsigned), then peak_val <= out_val and peak_neg <= out_neg; ties keep the old value; clr_stats clears both.
REQ-035 Without INTERP_PEAK_EN, peak_val and peak_neg shall be constant 0, with no compare logic or registers; all other behaviour is unchanged.

Verification
REQ-036 WIDTH 8, signed, in_data 0xF6, out_ready 1 -> out_valid 2 cycles later, out_val 0x0A, out_neg 1, out_zero 0.
REQ-037 Back-to-back 0x80 signed, 0x80 unsigned, 0x00 signed -> outputs (0x80,1), (0x80,0), (0x00,0, zero 1) on consecutive cycles.
REQ-038 Out_ready held low for 5 cycles with 3 samples offered -> exactly 2 accepted, in_ready low, out data stable; release -> order preserved, no loss or duplication.
REQ-039 With INTERP_PEAK_EN, signed samples 0x05, 0xF0, 0x10, 0x7F -> peak ends (0x7F, 0); after 0xF0 the peak is (0x10, 1); sample_cnt 4.
REQ-040 clr_stats pulsed on the same cycle as an output handshake -> sample_cnt 0, peak 0 next cycle; CNT_W 2 with 5 samples -> sample_cnt 3.
REQ-041 rst_n dropped asynchronously with both stages full -> out_valid low before the next edge, no handshake; after release, the first new sample appears with latency 2.
